// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined cpu.
// It holds the cpu in reset for a fixed number of cycles after Start, then counts run cycles.
// A run ends when the fetch PC stays unchanged for a set number of cycles (halt) or when the cycle limit is reached.
// Every data-memory write made during the run is captured in a first-word-fall-through trace FIFO.
module cpu_run_ctrl #(
  parameter int SIZE         = 48,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_CYCLES  = 4,
  parameter int MAX_CYCLES   = 1024,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             Start,
  output logic                             CpuReset,
  input  logic [SIZE-1:0]                  PCF,
  input  logic                             MemWriteM,
  input  logic [SIZE-1:0]                  ALUOutM,
  input  logic [SIZE-1:0]                  WriteDataM,
  output logic                             Running,
  output logic                             Done,
  output logic                             Timeout,
  output logic [$clog2(MAX_CYCLES+1)-1:0]  CycleCount,
  input  logic                             TraceRdEn,
  output logic                             TraceValid,
  output logic [SIZE-1:0]                  TraceAddr,
  output logic [SIZE-1:0]                  TraceData,
  output logic [$clog2(TRACE_DEPTH+1)-1:0] TraceCount,
  output logic                             TraceOverflow
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int TW = $clog2(TRACE_DEPTH + 1);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int HW = $clog2(HALT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  localparam logic [RW-1:0] RC_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HALT_CYCLES - 1);
  localparam logic [CW-1:0] MC_MAX  = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] MC_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [TW-1:0] DEPTH   = TW'(TRACE_DEPTH);

  typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;

  state_t            state;
  logic [RW-1:0]     rst_cnt;
  logic [HW-1:0]     stable_cnt;
  logic [SIZE-1:0]   prev_pc;

  logic              pc_same;
  logic              halt_hit;
  logic              time_hit;
  logic [CW-1:0]     cyc_inc;
  logic [HW-1:0]     stable_nxt;

  logic [2*SIZE-1:0] mem [TRACE_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [2*SIZE-1:0] head;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              flush;

  // Run-end detection: halt on a stable PC, timeout when the next count would reach the limit
  always_comb begin
    pc_same    = (PCF == prev_pc);
    halt_hit   = pc_same && (stable_cnt == HC_LAST);
    time_hit   = (CycleCount == MC_LAST);
    cyc_inc    = (CycleCount == MC_MAX) ? MC_MAX : CycleCount + 1'b1;
    stable_nxt = pc_same ? stable_cnt + 1'b1 : '0;
  end

  // Previous fetch PC, sampled every cycle for the halt comparison
  always_ff @(posedge CLK) begin
    prev_pc <= PCF;
  end

  // Run sequencer: state together with its registered outputs and counters
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      CpuReset   <= 1'b1;
      Running    <= 1'b0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      CycleCount <= '0;
      rst_cnt    <= '0;
      stable_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state      <= RST_HOLD;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            CycleCount <= '0;
            rst_cnt    <= '0;
          end
        end
        RST_HOLD: begin
          if (rst_cnt == RC_LAST) begin
            state      <= RUN;
            CpuReset   <= 1'b0;
            Running    <= 1'b1;
            stable_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          CycleCount <= cyc_inc;
          stable_cnt <= stable_nxt;
          if (time_hit || halt_hit) begin
            state    <= DONE;
            CpuReset <= 1'b1;
            Running  <= 1'b0;
            Done     <= 1'b1;
            // A timeout takes precedence when both conditions land together
            Timeout  <= time_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control: a push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  always_comb begin
    push  = (state == RUN) && MemWriteM;
    pop   = TraceRdEn && TraceValid;
    full  = (TraceCount == DEPTH);
    wr_en = push && (!full || pop);
    flush = (state == DONE) && Start;
    head  = mem[rd_ptr];
  end

  // Trace storage, no reset needed since entries are only visible while counted
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {ALUOutM, WriteDataM};
  end

  // Trace pointers, occupancy and the sticky overflow flag
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      TraceCount    <= '0;
      TraceOverflow <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      TraceCount    <= '0;
      TraceOverflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      TraceCount <= TraceCount + 1'b1;
      else if (!wr_en && pop) TraceCount <= TraceCount - 1'b1;
      if (push && full && !pop) TraceOverflow <= 1'b1;
    end
  end

  // Head entry is presented as zero while the FIFO is empty
  always_comb begin
    TraceValid = (TraceCount != '0);
    TraceAddr  = TraceValid ? head[2*SIZE-1:SIZE] : '0;
    TraceData  = TraceValid ? head[SIZE-1:0] : '0;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed and random stimulus compared each cycle against a reference model.
module tb_cpu_run_ctrl;

  localparam int SIZE = 48;
  localparam int RC   = 2;
  localparam int HC   = 4;
  localparam int MC   = 1024;
  localparam int TD   = 16;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic            CLK = 1'b0;
  logic            Reset = 1'b0;
  logic            Start = 1'b0;
  logic            MemWriteM = 1'b0;
  logic            TraceRdEn = 1'b0;
  logic [SIZE-1:0] PCF = '0;
  logic [SIZE-1:0] ALUOutM = '0;
  logic [SIZE-1:0] WriteDataM = '0;
  logic            CpuReset, Running, Done, Timeout, TraceValid, TraceOverflow;
  logic [10:0]     CycleCount;
  logic [4:0]      TraceCount;
  logic [SIZE-1:0] TraceAddr, TraceData;

  cpu_run_ctrl #(.SIZE(SIZE), .RESET_CYCLES(RC), .HALT_CYCLES(HC), .MAX_CYCLES(MC), .TRACE_DEPTH(TD)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .CpuReset(CpuReset), .PCF(PCF),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .Running(Running), .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount),
    .TraceRdEn(TraceRdEn), .TraceValid(TraceValid), .TraceAddr(TraceAddr),
    .TraceData(TraceData), .TraceCount(TraceCount), .TraceOverflow(TraceOverflow)
  );

  always #5 CLK = ~CLK;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: run phase, counters and the trace kept as a queue
  int              m_phase, m_hold, m_cyc, m_stable;
  bit              m_tmo, m_ovf;
  logic [SIZE-1:0] m_prev;
  logic [2*SIZE-1:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_phase = M_IDLE; m_hold = 0; m_cyc = 0; m_stable = 0;
    m_tmo = 1'b0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic mstep();
    bit pop, push;
    pop  = TraceRdEn && (m_q.size() != 0);
    push = (m_phase == M_RUN) && MemWriteM;
    if (m_phase == M_DONE && Start) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < TD) m_q.push_back({ALUOutM, WriteDataM});
        else m_ovf = 1'b1;
      end
    end
    case (m_phase)
      M_IDLE, M_DONE: if (Start) begin m_phase = M_HOLD; m_hold = RC; m_cyc = 0; m_tmo = 1'b0; end
      M_HOLD: begin
        m_hold--;
        if (m_hold == 0) begin m_phase = M_RUN; m_stable = 0; end
      end
      M_RUN: begin
        m_cyc    = (m_cyc < MC) ? m_cyc + 1 : MC;
        m_stable = (PCF == m_prev) ? m_stable + 1 : 0;
        if (m_cyc == MC) begin m_phase = M_DONE; m_tmo = 1'b1; end
        else if (m_stable >= HC) m_phase = M_DONE;
      end
      default: ;
    endcase
    m_prev = PCF;
  endtask

  task automatic check_all();
    logic [2*SIZE-1:0] h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    chk("CpuReset",      64'(CpuReset),      64'(m_phase != M_RUN));
    chk("Running",       64'(Running),       64'(m_phase == M_RUN));
    chk("Done",          64'(Done),          64'(m_phase == M_DONE));
    chk("Timeout",       64'(Timeout),       64'(m_tmo));
    chk("CycleCount",    64'(CycleCount),    64'(m_cyc));
    chk("TraceValid",    64'(TraceValid),    64'(m_q.size() != 0));
    chk("TraceCount",    64'(TraceCount),    64'(m_q.size()));
    chk("TraceOverflow", 64'(TraceOverflow), 64'(m_ovf));
    chk("TraceAddr",     64'(TraceAddr),     64'(h[2*SIZE-1:SIZE]));
    chk("TraceData",     64'(TraceData),     64'(h[SIZE-1:0]));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!Reset) begin mreset(); m_prev = PCF; end
    else mstep();
    @(negedge CLK);
    check_all();
  endtask

  logic [SIZE-1:0] wa [3];
  logic [SIZE-1:0] wd [3];
  logic [SIZE-1:0] fd [19];

  initial begin
    wa[0] = 48'h10; wa[1] = 48'h14; wa[2] = 48'h18;
    wd[0] = 48'hAA; wd[1] = 48'hBB; wd[2] = 48'hCC;
    mreset();
    m_prev = '0;

    // Reset held for three cycles, then Start and the cpu reset hold window
    repeat (3) tick();
    Reset = 1'b1;
    PCF = 48'hFFF0;
    tick(); tick();
    Start = 1'b1; tick(); Start = 1'b0;
    chk("hold1_cpureset", 64'(CpuReset), 64'd1);
    tick();
    chk("hold2_running", 64'(Running), 64'd0);
    tick();
    chk("run_entry_running", 64'(Running), 64'd1);
    chk("run_entry_count", 64'(CycleCount), 64'd0);

    // PC walks 0,4,..,0x40 with three traced writes, then sticks at 0x40 until halt
    for (int i = 0; i <= 16; i++) begin
      PCF = SIZE'(i * 4);
      MemWriteM = (i >= 1 && i <= 3);
      if (i >= 1 && i <= 3) begin ALUOutM = wa[i-1]; WriteDataM = wd[i-1]; end
      tick();
    end
    MemWriteM = 1'b0;
    for (int k = 0; k < 10 && m_phase != M_DONE; k++) tick();
    chk("halt_done", 64'(Done), 64'd1);
    chk("halt_timeout", 64'(Timeout), 64'd0);
    chk("halt_count", 64'(CycleCount), 64'd21);
    repeat (3) tick();
    chk("halt_count_frozen", 64'(CycleCount), 64'd21);
    chk("trace3_count", 64'(TraceCount), 64'd3);

    // Drain the three entries in order, plus one pop while empty
    TraceRdEn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("trace3_addr", 64'(TraceAddr), 64'(wa[j]));
      chk("trace3_data", 64'(TraceData), 64'(wd[j]));
      tick();
    end
    chk("trace3_empty", 64'(TraceValid), 64'd0);
    tick();
    TraceRdEn = 1'b0;

    // Toggling PC runs into the cycle limit; random writes, pops and ignored Starts
    Start = 1'b1; tick(); Start = 1'b0;
    for (int c = 0; c < 1200 && m_phase != M_DONE; c++) begin
      PCF        = c[0] ? 48'h104 : 48'h100;
      MemWriteM  = 1'($urandom_range(0, 1));
      ALUOutM    = SIZE'({$urandom, $urandom});
      WriteDataM = SIZE'({$urandom, $urandom});
      TraceRdEn  = ($urandom_range(0, 3) == 0);
      Start      = ($urandom_range(0, 31) == 0);
      tick();
    end
    Start = 1'b0; TraceRdEn = 1'b0;
    chk("tmo_done", 64'(Done), 64'd1);
    chk("tmo_flag", 64'(Timeout), 64'd1);
    chk("tmo_count", 64'(CycleCount), 64'd1024);
    chk("tmo_cpureset", 64'(CpuReset), 64'd1);
    MemWriteM = 1'b1; tick(); MemWriteM = 1'b0;
    TraceRdEn = 1'b1; repeat (5) tick(); TraceRdEn = 1'b0;

    // Start from DONE flushes, then fill the FIFO past its depth
    Start = 1'b1; tick(); Start = 1'b0;
    chk("flush_count", 64'(TraceCount), 64'd0);
    chk("flush_timeout", 64'(Timeout), 64'd0);
    chk("flush_overflow", 64'(TraceOverflow), 64'd0);
    tick(); tick();
    for (int i = 0; i < 19; i++) begin
      PCF        = SIZE'(48'h200 + i);
      MemWriteM  = 1'b1;
      ALUOutM    = SIZE'(48'h1000 + i);
      fd[i]      = SIZE'({$urandom, $urandom});
      WriteDataM = fd[i];
      TraceRdEn  = (i == 16);
      tick();
      if (i == 15) begin
        chk("full_count", 64'(TraceCount), 64'd16);
        chk("full_no_ovf", 64'(TraceOverflow), 64'd0);
      end
      if (i == 16) begin
        chk("pushpop_count", 64'(TraceCount), 64'd16);
        chk("pushpop_no_ovf", 64'(TraceOverflow), 64'd0);
      end
    end
    MemWriteM = 1'b0; TraceRdEn = 1'b0;
    chk("ovf_count", 64'(TraceCount), 64'd16);
    chk("ovf_flag", 64'(TraceOverflow), 64'd1);
    chk("ovf_head_addr", 64'(TraceAddr), 64'h1001);
    chk("ovf_head_data", 64'(TraceData), 64'(fd[1]));
    for (int k = 0; k < 10 && m_phase != M_DONE; k++) tick();
    chk("ovf_run_done", 64'(Done), 64'd1);
    TraceRdEn = 1'b1;
    repeat (16) tick();
    TraceRdEn = 1'b0;
    chk("ovf_drained", 64'(TraceValid), 64'd0);

    // Asynchronous reset in the middle of a run with five entries held
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      PCF = SIZE'(48'h300 + 4 * i);
      MemWriteM = 1'b1;
      ALUOutM = SIZE'(48'h2000 + i);
      WriteDataM = SIZE'($urandom);
      tick();
    end
    MemWriteM = 1'b0;
    chk("pre_reset_count", 64'(TraceCount), 64'd5);
    Reset = 1'b0;
    #1;
    mreset();
    check_all();
    chk("async_cpureset", 64'(CpuReset), 64'd1);
    chk("async_addr", 64'(TraceAddr), 64'd0);
    tick(); tick();
    Reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
